regfile_sb: RTL



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_sb_scoreboard.sv | 74 +++++++
 rtl/regfile_sb.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy-bit scoreboard.
package regfile_pkg;

  localparam int RF_N     = 8;
  localparam int RF_DEPTH = 32;
  localparam int RF_NRD   = 2;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  // Register address for the default-depth configuration.
  typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one busy bit per register, a population counter of
// the busy bits and a sticky WAW-issue error flag. R0 and out-of-range
// addresses are never busy and are never marked.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = RF_NRD,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   w,
  input  logic [AW-1:0]          Rd,
  input  logic                   mark,
  input  logic [AW-1:0]          Rm,
  input  logic [NRD-1:0][AW-1:0] lk_addr,
  output logic [NRD-1:0]         lk_busy,
  output logic [AW:0]            busy_cnt,
  output logic                   err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // True for a real, writable register: not R0 and below DEPTH.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_W);
  endfunction

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             err_q, err_d;
  logic             wr_ok, mk_ok, inc, dec;

  // Next busy vector, counter and error flag; a mark wins over a clearing write.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    err_d      = err_q;
    wr_ok      = w && addr_ok(Rd);
    mk_ok      = mark && addr_ok(Rm);
    inc        = mk_ok && !busy_q[Rm];
    dec        = wr_ok && busy_q[Rd] && !(mk_ok && (Rm == Rd));
    if (wr_ok) busy_d[Rd] = 1'b0;
    if (mk_ok) busy_d[Rm] = 1'b1;
    if (mk_ok && busy_q[Rm]) err_d = 1'b1;
    busy_cnt_d = busy_cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  // Scoreboard state; reset discards every pending operation.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
    end
  end

  // Registered busy state seen by each lookup port.
  always_comb begin
    lk_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      lk_busy[i] = addr_ok(lk_addr[i]) && busy_q[lk_addr[i]];
    end
  end

  assign busy_cnt = busy_cnt_q;
  assign err      = err_q;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file: one write port, NRD combinational read
// ports with optional write-to-read bypass, and a busy-bit scoreboard used
// by decode for operand hazard detection. R0 always reads zero.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int N      = RF_N,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NRD    = RF_NRD,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   w,
  input  logic [AW-1:0]          Rd,
  input  logic [N-1:0]           w_data,
  output logic [N-1:0]           Rd_data,
  input  logic [NRD-1:0][AW-1:0] Rs,
  output logic [NRD-1:0][N-1:0]  Rs_data,
  input  logic                   mark,
  input  logic [AW-1:0]          Rm,
  output logic [NRD-1:0]         rs_busy,
  output logic                   hazard,
  output logic [AW:0]            busy_cnt,
  output logic                   err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // True for a real, writable register: not R0 and below DEPTH.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_W);
  endfunction

  logic [N-1:0]   gpr_q [DEPTH];
  logic [N-1:0]   gpr_d [DEPTH];
  logic           wr_ok;
  logic [NRD-1:0] lk_busy;
  logic [NRD-1:0] byp;

  assign wr_ok = w && addr_ok(Rd);

  // Next data array: a single write per cycle, R0 and out-of-range ignored.
  always_comb begin
    gpr_d = gpr_q;
    if (wr_ok) gpr_d[Rd] = w_data;
  end

  // Data array storage.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) gpr_q[i] <= '0;
    end else begin
      gpr_q <= gpr_d;
    end
  end

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .n_reset  (n_reset),
    .w        (w),
    .Rd       (Rd),
    .mark     (mark),
    .Rm       (Rm),
    .lk_addr  (Rs),
    .lk_busy  (lk_busy),
    .busy_cnt (busy_cnt),
    .err      (err)
  );

  // Read ports; a bypassed port sees the incoming data and a result no
  // longer pending. Rd_data never bypasses.
  always_comb begin
    byp     = '0;
    rs_busy = '0;
    Rs_data = '0;
    Rd_data = addr_ok(Rd) ? gpr_q[Rd] : '0;
    for (int i = 0; i < NRD; i++) begin
      byp[i]     = (BYPASS != 0) && wr_ok && (Rs[i] == Rd);
      Rs_data[i] = byp[i] ? w_data : (addr_ok(Rs[i]) ? gpr_q[Rs[i]] : '0);
      rs_busy[i] = lk_busy[i] && !byp[i];
    end
  end

  assign hazard = |rs_busy;

endmodule
